// File: rtl/clock_pkg.sv
// Shared types and time-range constants for the alarm controller.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_e;

  localparam logic [7:0] HOUR_MIN = 8'd1;
  localparam logic [7:0] HOUR_MAX = 8'd12;
  localparam logic [7:0] MIN_MAX  = 8'd59;

  function automatic logic set_time_ok(input logic [7:0] hh, input logic [7:0] mm);
    return (hh >= HOUR_MIN) && (hh <= HOUR_MAX) && (mm <= MIN_MAX);
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Time, control and status bundle between the alarm controller and its host.
interface alarm_controller_if;

  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       am_pm;
  logic       alarm_en;
  logic       set_valid;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic       set_am_pm;
  logic       snooze;
  logic       stop;
  logic       ring;
  logic       snoozing;
  logic       armed;
  logic [7:0] alarm_hh;
  logic [7:0] alarm_mm;
  logic       alarm_am_pm;
  logic [3:0] snooze_cnt;
  logic       set_err;

  modport master (
    output hh, mm, ss, am_pm, alarm_en, set_valid, set_hh, set_mm, set_am_pm, snooze, stop,
    input  ring, snoozing, armed, alarm_hh, alarm_mm, alarm_am_pm, snooze_cnt, set_err
  );

  modport slave (
    input  hh, mm, ss, am_pm, alarm_en, set_valid, set_hh, set_mm, set_am_pm, snooze, stop,
    output ring, snoozing, armed, alarm_hh, alarm_mm, alarm_am_pm, snooze_cnt, set_err
  );

endinterface

// File: rtl/alarm_sec_timer.sv
// 16-bit loadable seconds down-counter; holds at zero instead of wrapping.
module alarm_sec_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_nsec,
  output logic [15:0] o_value,
  output logic        o_zero
);

  logic [15:0] r_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_value <= '0;
    else if (i_load)
      r_value <= i_load_val;
    else if (i_nsec && (r_value != 16'd0))
      r_value <= r_value - 16'd1;
  end

  assign o_value = r_value;
  assign o_zero  = (r_value == 16'd0);

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock controller: arm, ring, snooze and auto-silence against an upstream time of day.
module alarm_controller
  import clock_pkg::*;
#(
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic               clk,
  input  logic               reset,
  alarm_controller_if.slave  bus
);

  localparam logic [15:0] RING_LD   = 16'(RING_SEC);
  localparam logic [15:0] SNOOZE_LD = 16'(SNOOZE_SEC);
  localparam logic [3:0]  MAX_CNT   = 4'(MAX_SNOOZE);

  alarm_state_e r_state, w_nxt;
  logic [7:0]   r_ss_q, r_alarm_hh, r_alarm_mm;
  logic         r_alarm_am_pm, r_ring, r_snoozing, r_armed, r_set_err;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic         w_nsec, w_match, w_expire, w_ld, w_err_nxt, w_store;
  logic [15:0]  w_ld_val, w_tmr_val;
  logic         w_tmr_zero;

  assign w_nsec   = (bus.ss != r_ss_q);
  assign w_match  = (bus.hh == r_alarm_hh) && (bus.mm == r_alarm_mm) &&
                    (bus.am_pm == r_alarm_am_pm) && (bus.ss == 8'd0) && w_nsec;
  // The timer reaches zero on this very edge, so the state change lines up with it.
  assign w_expire = w_nsec && (w_tmr_zero || (w_tmr_val == 16'd1));

  alarm_sec_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_ld),
    .i_load_val (w_ld_val),
    .i_nsec     (w_nsec),
    .o_value    (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_ld      = 1'b0;
    w_ld_val  = '0;
    w_err_nxt = 1'b0;
    w_store   = 1'b0;
    if (!bus.alarm_en) begin
      w_nxt     = ST_IDLE;
      w_cnt_nxt = '0;
      w_ld      = 1'b1;
    end else if (bus.set_valid) begin
      if (set_time_ok(bus.set_hh, bus.set_mm)) begin
        w_store   = 1'b1;
        w_nxt     = ST_ARMED;
        w_cnt_nxt = '0;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: w_nxt = ST_ARMED;
        ST_ARMED: begin
          if (w_match) begin
            w_nxt    = ST_RINGING;
            w_ld     = 1'b1;
            w_ld_val = RING_LD;
          end
        end
        ST_RINGING: begin
          if (bus.stop) begin
            w_nxt     = ST_ARMED;
            w_cnt_nxt = '0;
          end else if (bus.snooze && (r_cnt < MAX_CNT)) begin
            w_nxt     = ST_SNOOZE;
            w_cnt_nxt = r_cnt + 4'd1;
            w_ld      = 1'b1;
            w_ld_val  = SNOOZE_LD;
          end else if (w_expire) begin
            w_nxt     = ST_ARMED;
            w_cnt_nxt = '0;
          end
        end
        ST_SNOOZE: begin
          if (bus.stop) begin
            w_nxt     = ST_ARMED;
            w_cnt_nxt = '0;
          end else if (w_expire) begin
            w_nxt    = ST_RINGING;
            w_ld     = 1'b1;
            w_ld_val = RING_LD;
          end
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ss_q        <= '0;
      r_cnt         <= '0;
      r_ring        <= 1'b0;
      r_snoozing    <= 1'b0;
      r_armed       <= 1'b0;
      r_set_err     <= 1'b0;
      r_alarm_hh    <= HOUR_MAX;
      r_alarm_mm    <= '0;
      r_alarm_am_pm <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_ss_q     <= bus.ss;
      r_cnt      <= w_cnt_nxt;
      r_ring     <= (w_nxt == ST_RINGING);
      r_snoozing <= (w_nxt == ST_SNOOZE);
      r_armed    <= (w_nxt == ST_ARMED);
      r_set_err  <= w_err_nxt;
      if (w_store) begin
        r_alarm_hh    <= bus.set_hh;
        r_alarm_mm    <= bus.set_mm;
        r_alarm_am_pm <= bus.set_am_pm;
      end
    end
  end

  assign bus.ring        = r_ring;
  assign bus.snoozing    = r_snoozing;
  assign bus.armed       = r_armed;
  assign bus.set_err     = r_set_err;
  assign bus.snooze_cnt  = r_cnt;
  assign bus.alarm_hh    = r_alarm_hh;
  assign bus.alarm_mm    = r_alarm_mm;
  assign bus.alarm_am_pm = r_alarm_am_pm;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed vector bench for alarm_controller with SNOOZE_SEC=3, RING_SEC=5, MAX_SNOOZE=2.
module tb_alarm_controller;

  typedef struct {
    logic       en, sv;
    logic [7:0] shh, smm;
    logic       sap;
    logic [7:0] hh, mm, ss;
    logic       ap, snz, stp;
    logic       e_ring, e_snz, e_arm;
    logic [3:0] e_cnt;
    logic       e_err;
    logic [7:0] e_ahh, e_amm;
    logic       e_aap;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[$];

  alarm_controller_if bus();

  alarm_controller #(.SNOOZE_SEC(3), .RING_SEC(5), .MAX_SNOOZE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int en, int sv, int shh, int smm, int sap,
                              int hh, int mm, int ss, int ap, int snz, int stp,
                              int ring, int snzo, int arm, int cnt, int err,
                              int ahh, int amm, int aap);
    vec_t v;
    v.en = 1'(en);     v.sv = 1'(sv);     v.shh = 8'(shh);  v.smm = 8'(smm);
    v.sap = 1'(sap);   v.hh = 8'(hh);     v.mm = 8'(mm);    v.ss = 8'(ss);
    v.ap = 1'(ap);     v.snz = 1'(snz);   v.stp = 1'(stp);
    v.e_ring = 1'(ring); v.e_snz = 1'(snzo); v.e_arm = 1'(arm);
    v.e_cnt = 4'(cnt); v.e_err = 1'(err);
    v.e_ahh = 8'(ahh); v.e_amm = 8'(amm); v.e_aap = 1'(aap);
    return v;
  endfunction

  function automatic logic [24:0] outs();
    return {bus.ring, bus.snoozing, bus.armed, bus.snooze_cnt, bus.set_err,
            bus.alarm_hh, bus.alarm_mm, bus.alarm_am_pm};
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got ring/snz/arm/cnt/err/ahh/amm/aap=%h required %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string name);
    bus.alarm_en  = v.en;
    bus.set_valid = v.sv;
    bus.set_hh    = v.shh;
    bus.set_mm    = v.smm;
    bus.set_am_pm = v.sap;
    bus.hh        = v.hh;
    bus.mm        = v.mm;
    bus.ss        = v.ss;
    bus.am_pm     = v.ap;
    bus.snooze    = v.snz;
    bus.stop      = v.stp;
    tick();
    check(name, outs(), {v.e_ring, v.e_snz, v.e_arm, v.e_cnt, v.e_err, v.e_ahh, v.e_amm, v.e_aap});
  endtask

  initial begin
    bus.alarm_en = 0; bus.set_valid = 0; bus.set_hh = 0; bus.set_mm = 0; bus.set_am_pm = 0;
    bus.hh = 8'd12; bus.mm = 0; bus.ss = 0; bus.am_pm = 0; bus.snooze = 0; bus.stop = 0;

    //           en sv shh smm sap  hh mm ss ap snz stp  ring snz arm cnt err  ahh amm aap
    vecs.push_back(mk(1, 0, 0, 0, 0,  12, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0,  12, 0, 0));
    vecs.push_back(mk(1, 1, 7, 30, 0, 12, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 1, 13, 0, 0, 12, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  12, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 1, 7, 60, 0, 12, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1,  7, 30, 0));
    vecs.push_back(mk(1, 1, 0, 30, 0, 12, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 29, 59, 0, 0, 0, 0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 1, 0, 0,  0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 29, 59, 0, 0, 0, 0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 0, 0,  1, 0, 0, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 0, 0,  1, 0, 0, 0, 0,  7, 30, 0));
    for (int s = 1; s <= 4; s++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 7, 30, s, 0, 0, 0, 1, 0, 0, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 5, 0, 0, 0,  0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 29, 59, 0, 0, 0, 0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 0, 0,  1, 0, 0, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 1, 0,  0, 1, 0, 1, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 1, 0,  0, 1, 0, 1, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 1, 0, 0, 0,  0, 1, 0, 1, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 2, 0, 0, 0,  0, 1, 0, 1, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 3, 0, 0, 0,  1, 0, 0, 1, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 3, 0, 1, 0,  0, 1, 0, 2, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 4, 0, 0, 0,  0, 1, 0, 2, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 5, 0, 0, 0,  0, 1, 0, 2, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 6, 0, 0, 0,  1, 0, 0, 2, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 7, 0, 0, 0,  1, 0, 0, 2, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 7, 0, 1, 0,  1, 0, 0, 2, 0,  7, 30, 0));
    for (int s = 8; s <= 10; s++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 7, 30, s, 0, 0, 0, 1, 0, 0, 2, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 11, 0, 0, 0, 0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 29, 59, 0, 0, 0, 0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 0, 0,  1, 0, 0, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 1, 1,  0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 29, 59, 0, 0, 0, 0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 0, 0,  1, 0, 0, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 1, 0,  0, 1, 0, 1, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 0, 1,  0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 29, 59, 0, 0, 0, 0, 0, 1, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 0, 0,  1, 0, 0, 0, 0,  7, 30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 1, 0,  0, 1, 0, 1, 0,  7, 30, 0));
    vecs.push_back(mk(1, 1, 6, 15, 1, 7, 30, 0, 0, 0, 0,  0, 0, 1, 0, 0,  6, 15, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  7, 30, 0, 0, 0, 0,  0, 0, 0, 0, 0,  6, 15, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7, 30, 0, 0, 0, 0,  0, 0, 1, 0, 0,  6, 15, 1));

    #12;
    check("reset_state", outs(), {1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd12, 8'd0, 1'b0});
    @(posedge clk);
    #1 reset = 1'b0;
    check("after_release", outs(), {1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd12, 8'd0, 1'b0});

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Multi-cycle corner: ring at 06:15 PM, snooze, then asynchronous reset mid-snooze.
    apply(mk(1, 0, 0, 0, 0, 6, 14, 59, 1, 0, 0, 0, 0, 1, 0, 0, 6, 15, 1), "pm_pre");
    apply(mk(1, 0, 0, 0, 0, 6, 15, 0, 1, 0, 0,  1, 0, 0, 0, 0, 6, 15, 1), "pm_ring");
    apply(mk(1, 0, 0, 0, 0, 6, 15, 0, 1, 1, 0,  0, 1, 0, 1, 0, 6, 15, 1), "pm_snooze");
    #3 reset = 1'b1;
    #1;
    check("async_reset_snooze", outs(), {1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd12, 8'd0, 1'b0});
    bus.hh = 8'd12; bus.mm = 0; bus.ss = 0; bus.am_pm = 0; bus.snooze = 0;
    tick();
    check("held_in_reset", outs(), {1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd12, 8'd0, 1'b0});
    reset = 1'b0;

    // Alarm defaults to 12:00 AM; no ring at release, ring on a real midnight rollover.
    apply(mk(1, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12, 0, 0), "rel_armed");
    apply(mk(1, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12, 0, 0), "rel_quiet");
    apply(mk(1, 0, 0, 0, 0, 11, 59, 59, 1, 0, 0, 0, 0, 1, 0, 0, 12, 0, 0), "midnight_pre");
    apply(mk(1, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 12, 0, 0), "midnight_ring");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter SNOOZE_SEC, default 300, snooze duration in seconds (1..65535).
REQ-002 Parameter RING_SEC, default 60, auto-silence timeout in seconds (1..65535).
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (1..15).
REQ-004 clk  input  1  single clock; all state on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 hh / mm / ss  input  8 each  current time from upstream clock (hh 1..12, mm/ss 0..59, binary).
REQ-007 am_pm  input  1  current half-day, 0 = AM, 1 = PM.
REQ-008 alarm_en  input  1  level; 0 disarms and silences.
REQ-009 set_valid  input  1  one-cycle load strobe for set_hh/set_mm/set_am_pm.
REQ-010 set_hh / set_mm  input  8 each  requested alarm time; set_am_pm  input  1.
REQ-011 snooze / stop  input  1 each  one-cycle button pulses.
REQ-012 ring  output  1  alarm sounding.
REQ-013 snoozing / armed  output  1 each  state indicators.
REQ-014 alarm_hh / alarm_mm  output  8 each; alarm_am_pm  output  1  stored alarm time.
REQ-015 snooze_cnt  output  4  snoozes used in current event.
REQ-016 set_err  output  1  one-cycle pulse, set rejected.

Function
REQ-017 FSM states IDLE, ARMED, RINGING, SNOOZE; all outputs registered.
REQ-018 New-second event (nsec) SHALL be ss != ss_q, ss_q the previous-cycle ss.
REQ-019 Match SHALL be hh==alarm_hh, mm==alarm_mm, am_pm==alarm_am_pm, ss==0 and nsec; fires at most once per minute.
REQ-020 Priority per cycle: alarm_en=0, then set_valid, then stop, then snooze, then match/timers.
REQ-021 alarm_en=0 in any state -> IDLE next cycle; ring=0, snoozing=0, snooze_cnt=0.
REQ-022 IDLE with alarm_en=1 -> ARMED next cycle.
REQ-023 set_valid with set_hh in 1..12 and set_mm<=59: store values next cycle; RINGING/SNOOZE -> ARMED, snooze_cnt=0.
REQ-024 set_valid with out-of-range value: stored time unchanged, state unchanged, set_err=1 for exactly one cycle.
REQ-025 ARMED and match -> RINGING; ring=1 the cycle after ss shows 0 (1-cycle latency); ring timer loaded RING_SEC.
REQ-026 RINGING: ring timer decrements on each nsec; reaching 0 -> ARMED, ring=0, snooze_cnt=0.
REQ-027 RINGING and stop -> ARMED, snooze_cnt=0; stop and snooze same cycle: stop wins.
REQ-028 RINGING and snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE, ring=0, snoozing=1, snooze_cnt+1, timer loaded SNOOZE_SEC.
REQ-029 RINGING and snooze with snooze_cnt==MAX_SNOOZE: ignored, stays RINGING, timer not reloaded.
REQ-030 SNOOZE: timer decrements on each nsec; reaching 0 -> RINGING, timer reloaded RING_SEC, snooze_cnt kept.
REQ-031 SNOOZE and stop -> ARMED, snoozing=0, snooze_cnt=0; snooze in SNOOZE ignored.
REQ-032 Match while RINGING or SNOOZE: ignored.
REQ-033 armed=1 in ARMED only; snoozing=1 in SNOOZE only; ring=1 in RINGING only.
REQ-034 Timer 16 bits unsigned, no wrap: decrement only when nonzero.

Reset
REQ-035 reset asserted: state IDLE, ring=0, snoozing=0, armed=0, set_err=0, snooze_cnt=0, timer=0.
REQ-036 reset asserted: alarm_hh=12, alarm_mm=0, alarm_am_pm=0, ss_q=0.
REQ-037 Reset mid-RINGING/SNOOZE SHALL silence immediately (asynchronous); no event resumes after release.
REQ-038 Alarm 12:00 AM does not fire at reset release since upstream also resets to 12:00:00 (no nsec).

Structure
REQ-039 clock_pkg SHALL hold alarm_state_e enum, HOUR_MIN=1, HOUR_MAX=12, MIN_MAX=59 constants.
REQ-040 One sub-module alarm_sec_timer: 16-bit loadable down-counter, load/value/nsec inputs, zero flag output.

Verification (SNOOZE_SEC=3, RING_SEC=5, MAX_SNOOZE=2)
REQ-041 Set 07:30 AM, en=1, drive time to 07:30:00 AM -> ring=1 next cycle, armed=0.
REQ-042 Ringing, no buttons, 5 nsec events -> ring=0, armed=1, snooze_cnt=0.
REQ-043 Ringing, snooze -> snoozing=1, snooze_cnt=1; after 3 nsec -> ring=1; snooze, 3 nsec, snooze again -> ignored, ring stays 1, snooze_cnt=2.
REQ-044 Ringing, stop and snooze same cycle -> ARMED, ring=0, snooze_cnt=0.
REQ-045 set_valid with set_hh=13 or set_mm=60 -> set_err pulse one cycle, alarm_hh/alarm_mm unchanged.
REQ-046 Reset asserted mid-SNOOZE -> ring/snoozing 0 same cycle, alarm_hh=12, alarm_mm=0.
